voting_machine_n: RTL and testbench

- Parametrised N-candidate successor of the 3-candidate voting machine.
- Counts one vote per falling edge of a candidate button, then enforces a lockout (hold) window.
- Rejects ambiguous multi-button presses.
- When voting closes, snapshots the tallies and reports the winner and tie status to the display/readout logic.

---
 rtl/voting_machine_n_pkg.sv | 25 ++
 rtl/voting_machine_n_if.sv | 42 ++++
 rtl/voting_machine_n_argmax.sv | 38 +++
 rtl/voting_machine_n.sv | 144 ++++++++++++++
 tb/tb_voting_machine_n.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/voting_machine_n_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | voting_pkg                                                       |
// | Controller state type and saturating-increment helper.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package voting_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTE   = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Increment a counter of the given width (<=32 bits), sticking at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [32:0] w_limit;
    w_limit = (33'd1 << width) - 33'd1;
    if ({1'b0, value} >= w_limit) return value;
    return value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/voting_machine_n_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | voting_machine_n_if                                              |
// | Button/result bus of voting_machine_n (VM_AUDIT_EN adds counts). |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface voting_machine_n_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 16
);
  localparam int IDX_W = $clog2(NUM_CAND);

  logic [NUM_CAND-1:0]       i_cand;
  logic                      i_voting_over;
  logic [NUM_CAND*CNT_W-1:0] o_count;
  logic [IDX_W-1:0]          o_winner;
  logic                      o_tie;
  logic                      o_valid;
  logic                      o_vote_ack;
  logic                      o_vote_rej;
  logic                      o_busy;
`ifdef VM_AUDIT_EN
  logic [CNT_W+3:0]          o_total;
  logic [CNT_W-1:0]          o_rejected;
`endif

`ifdef VM_AUDIT_EN
  modport slave  (input  i_cand, i_voting_over,
                  output o_count, o_winner, o_tie, o_valid, o_vote_ack, o_vote_rej, o_busy,
                         o_total, o_rejected);
  modport master (output i_cand, i_voting_over,
                  input  o_count, o_winner, o_tie, o_valid, o_vote_ack, o_vote_rej, o_busy,
                         o_total, o_rejected);
`else
  modport slave  (input  i_cand, i_voting_over,
                  output o_count, o_winner, o_tie, o_valid, o_vote_ack, o_vote_rej, o_busy);
  modport master (output i_cand, i_voting_over,
                  input  o_count, o_winner, o_tie, o_valid, o_vote_ack, o_vote_rej, o_busy);
`endif

endinterface
`default_nettype wire

// File: rtl/voting_machine_n_argmax.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vm_argmax                                                        |
// | Combinational argmax/tie over a flattened tally bus.             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vm_argmax #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 16
) (
  input  wire logic [NUM_CAND*CNT_W-1:0]   i_tally,
  output logic      [$clog2(NUM_CAND)-1:0] o_idx,
  output logic                             o_tie
);
  localparam int IDX_W = $clog2(NUM_CAND);

  logic [CNT_W-1:0] w_max;
  logic [4:0]       w_hits;

  always_comb begin
    w_max  = '0;
    o_idx  = '0;
    w_hits = '0;
    // Strict greater-than keeps the lowest index on equal tallies.
    for (int k = 0; k < NUM_CAND; k++) begin
      if (i_tally[k*CNT_W +: CNT_W] > w_max) begin
        w_max = i_tally[k*CNT_W +: CNT_W];
        o_idx = IDX_W'(k);
      end
    end
    for (int k = 0; k < NUM_CAND; k++) begin
      if (i_tally[k*CNT_W +: CNT_W] == w_max) w_hits = w_hits + 5'd1;
    end
    o_tie = (w_hits > 5'd1);
  end

endmodule
`default_nettype wire

// File: rtl/voting_machine_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | voting_machine_n                                                 |
// | N-candidate falling-edge vote counter with lockout and results.  |
// | Optional VM_AUDIT_EN: total/rejected audit counters.             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module voting_machine_n
  import voting_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 15
) (
  input wire logic         clk,
  input wire logic         rst,
  voting_machine_n_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CAND);
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] c_hold_last = HC_W'(HOLD_CYCLES - 1);

  state_t                    r_state, w_next_state;
  logic [NUM_CAND-1:0]       r_prev, w_fall;
  logic [CNT_W-1:0]          r_tally [NUM_CAND];
  logic [NUM_CAND*CNT_W-1:0] w_tally_flat;
  logic [HC_W-1:0]           r_hold_cnt;
  logic                      w_any_edge, w_one_edge, w_take, w_enter_finish;
  logic [IDX_W-1:0]          w_edge_idx, w_max_idx;
  logic                      w_max_tie;
`ifdef VM_AUDIT_EN
  logic [CNT_W+3:0]          r_total;
  logic [CNT_W-1:0]          r_rejected;
`endif

  assign w_fall         = r_prev & ~bus.i_cand;
  assign w_any_edge     = |w_fall;
  assign w_one_edge     = w_any_edge && ((w_fall & (w_fall - NUM_CAND'(1))) == '0);
  assign w_take         = (r_state == VOTE) && !bus.i_voting_over && w_any_edge;
  assign w_enter_finish = (w_next_state == FINISH) && (r_state != FINISH);

  always_comb begin
    w_edge_idx = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      if (w_fall[k]) w_edge_idx = IDX_W'(k);
    end
  end

  for (genvar k = 0; k < NUM_CAND; k++) begin : g_pack
    assign w_tally_flat[k*CNT_W +: CNT_W] = r_tally[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_hold_cnt <= (r_state == HOLD) ? r_hold_cnt + HC_W'(1) : '0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = VOTE;
      VOTE:    if (bus.i_voting_over)            w_next_state = FINISH;
               else if (w_any_edge)              w_next_state = HOLD;
      HOLD:    if (bus.i_voting_over)            w_next_state = FINISH;
               else if (r_hold_cnt == c_hold_last) w_next_state = VOTE;
      FINISH:  if (!bus.i_voting_over)           w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy = (r_state == HOLD);
  end

  // Tallies persist across FINISH/IDLE; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev         <= '0;
      bus.o_vote_ack <= 1'b0;
      bus.o_vote_rej <= 1'b0;
      for (int k = 0; k < NUM_CAND; k++) r_tally[k] <= '0;
`ifdef VM_AUDIT_EN
      r_total        <= '0;
      r_rejected     <= '0;
`endif
    end else begin
      r_prev         <= bus.i_cand;
      bus.o_vote_ack <= w_take && w_one_edge;
      bus.o_vote_rej <= w_take && !w_one_edge;
      if (w_take && w_one_edge) begin
        r_tally[w_edge_idx] <= CNT_W'(sat_inc(32'(r_tally[w_edge_idx]), CNT_W));
`ifdef VM_AUDIT_EN
        r_total <= (CNT_W+4)'(sat_inc(32'(r_total), CNT_W + 4));
`endif
      end
`ifdef VM_AUDIT_EN
      if (w_take && !w_one_edge) r_rejected <= CNT_W'(sat_inc(32'(r_rejected), CNT_W));
`endif
    end
  end

  vm_argmax #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W)
  ) u_argmax (
    .i_tally (bus.o_count),
    .o_idx   (w_max_idx),
    .o_tie   (w_max_tie)
  );

  // Winner is derived from the snapshot one cycle after it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_count    <= '0;
      bus.o_winner   <= '0;
      bus.o_tie      <= 1'b0;
      bus.o_valid    <= 1'b0;
`ifdef VM_AUDIT_EN
      bus.o_total    <= '0;
      bus.o_rejected <= '0;
`endif
    end else begin
      if (w_enter_finish) begin
        bus.o_count    <= w_tally_flat;
`ifdef VM_AUDIT_EN
        bus.o_total    <= r_total;
        bus.o_rejected <= r_rejected;
`endif
      end
      if (r_state == FINISH) begin
        bus.o_winner <= w_max_idx;
        bus.o_tie    <= w_max_tie;
      end
      bus.o_valid <= (r_state == FINISH) && (w_next_state == FINISH);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voting_machine_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_voting_machine_n                                              |
// | Reference-model bench for voting_machine_n plus directed checks. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_voting_machine_n;
  localparam int NC = 4;
  localparam int CW = 16;
  localparam int HC = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  voting_machine_n_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();
  voting_machine_n_if #(.NUM_CAND(NC), .CNT_W(4))  sbus ();

  voting_machine_n #(.NUM_CAND(NC), .CNT_W(CW), .HOLD_CYCLES(HC)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  voting_machine_n #(.NUM_CAND(NC), .CNT_W(4), .HOLD_CYCLES(HC)) dut_sat (
    .clk (clk), .rst (rst), .bus (sbus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: tallies, remaining lockout cycles, open/closed flags.
  int            m_tally [NC];
  int            m_count [NC];
  int            m_hold_left, m_winner, m_best, m_hits, m_nf;
  bit            m_started, m_closed, m_tie, m_valid, m_ack, m_rej;
  logic [NC-1:0] m_prev, m_fall;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NC; k++) begin m_tally[k] = 0; m_count[k] = 0; end
      m_hold_left = 0; m_winner = 0; m_started = 0; m_closed = 0;
      m_tie = 0; m_valid = 0; m_ack = 0; m_rej = 0; m_prev = '0;
    end else begin
      m_fall = m_prev & ~bus.i_cand;
      m_prev = bus.i_cand;
      m_nf   = $countones(m_fall);
      m_ack  = 0;
      m_rej  = 0;
      if (!m_started) begin
        m_started = 1;
      end else if (m_closed) begin
        m_best = 0;
        for (int k = 0; k < NC; k++) if (m_count[k] > m_best) m_best = m_count[k];
        m_winner = -1; m_hits = 0;
        for (int k = 0; k < NC; k++) if (m_count[k] == m_best) begin
          m_hits++;
          if (m_winner < 0) m_winner = k;
        end
        m_tie   = (m_hits > 1);
        m_valid = bus.i_voting_over;
        if (!bus.i_voting_over) begin m_closed = 0; m_started = 0; end
      end else if (bus.i_voting_over) begin
        m_closed = 1; m_hold_left = 0;
        for (int k = 0; k < NC; k++) m_count[k] = m_tally[k];
      end else if (m_hold_left > 0) begin
        m_hold_left--;
      end else if (m_nf == 1) begin
        for (int k = 0; k < NC; k++) if (m_fall[k] && m_tally[k] < 65535) m_tally[k]++;
        m_ack = 1; m_hold_left = HC;
      end else if (m_nf > 1) begin
        m_rej = 1; m_hold_left = HC;
      end
    end
  end

  function automatic logic [63:0] exp_count();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NC; k++) v[k*CW +: CW] = CW'(m_count[k]);
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    chk("m_count",  bus.o_count, exp_count());
    chk("m_winner", 64'(bus.o_winner), 64'(m_winner));
    chk("m_tie",    64'(bus.o_tie), 64'(m_tie));
    chk("m_valid",  64'(bus.o_valid), 64'(m_valid));
    chk("m_ack",    64'(bus.o_vote_ack), 64'(m_ack));
    chk("m_rej",    64'(bus.o_vote_rej), 64'(m_rej));
    chk("m_busy",   64'(bus.o_busy), 64'(m_started && !m_closed && m_hold_left > 0));
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic vote(input logic [NC-1:0] mask);
    bus.i_cand = mask; cyc();
    bus.i_cand = '0;   cyc();
    repeat (HC + 1) cyc();
  endtask

  task automatic publish(input string tag, input logic [63:0] cnt, input int win, input bit tie);
    bus.i_voting_over = 1'b1; cyc();
    chk({tag, "_valid_early"}, 64'(bus.o_valid), 64'd0);
    chk({tag, "_count"}, bus.o_count, cnt);
    cyc();
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
    chk({tag, "_winner"}, 64'(bus.o_winner), 64'(win));
    chk({tag, "_tie"}, 64'(bus.o_tie), 64'(tie));
    bus.i_voting_over = 1'b0; cyc();
    chk({tag, "_valid_drop"}, 64'(bus.o_valid), 64'd0);
    cyc();
  endtask

  int busy_n;
  int sat_acks;

  initial begin
    bus.i_cand = '0;  bus.i_voting_over = 1'b0;
    sbus.i_cand = '0; sbus.i_voting_over = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_count", bus.o_count, 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_busy",  64'(bus.o_busy), 64'd0);
    rst = 1'b0;
    cyc();

    // Single vote for candidate 2
    bus.i_cand = 4'b0100; cyc();
    bus.i_cand = '0;      cyc();
    chk("t1_ack", 64'(bus.o_vote_ack), 64'd1);
    repeat (HC + 1) cyc();
    publish("t1", 64'h0000_0001_0000_0000, 2, 1'b0);

    // Simultaneous release of 0 and 3; a cand 1 release inside the lockout is lost
    bus.i_cand = 4'b1001; cyc();
    bus.i_cand = '0;      cyc();
    chk("t2_rej",  64'(bus.o_vote_rej), 64'd1);
    chk("t2_ack",  64'(bus.o_vote_ack), 64'd0);
    busy_n = bus.o_busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) bus.i_cand = 4'b0010;
      if (i == 2) bus.i_cand = '0;
      cyc();
      if (bus.o_busy) busy_n++;
    end
    chk("t2_busy_len", 64'(busy_n), 64'd15);
    publish("t2", 64'h0000_0001_0000_0000, 2, 1'b0);
    vote(4'b0010);
    publish("t3", 64'h0000_0001_0001_0000, 1, 1'b1);

    // Two-way tie between candidates 1 and 2
    vote(4'b0010); vote(4'b0010);
    vote(4'b0100); vote(4'b0100);
    vote(4'b0001);
    publish("t4", 64'h0000_0003_0003_0001, 1, 1'b1);

    // Reset in the middle of a lockout after five votes
    repeat (4) vote(4'b1000);
    bus.i_cand = 4'b1000; cyc();
    bus.i_cand = '0;      cyc();
    cyc(); cyc(); cyc();
    rst = 1'b1; cyc();
    chk("t6_busy",   64'(bus.o_busy), 64'd0);
    chk("t6_count",  bus.o_count, 64'd0);
    chk("t6_winner", 64'(bus.o_winner), 64'd0);
    chk("t6_tie",    64'(bus.o_tie), 64'd0);
    chk("t6_valid",  64'(bus.o_valid), 64'd0);
    rst = 1'b0; cyc();
    publish("t6", 64'd0, 0, 1'b1);

    // 4-bit tallies saturate at 15 while every vote is still acknowledged
    sat_acks = 0;
    for (int v = 0; v < 17; v++) begin
      sbus.i_cand = 4'b0001; cyc();
      sbus.i_cand = '0;      cyc();
      if (sbus.o_vote_ack) sat_acks++;
      repeat (HC + 1) cyc();
    end
    chk("t5_acks", 64'(sat_acks), 64'd17);
    sbus.i_voting_over = 1'b1; cyc(); cyc();
    chk("t5_count",  64'(sbus.o_count), 64'h000F);
    chk("t5_winner", 64'(sbus.o_winner), 64'd0);
    chk("t5_tie",    64'(sbus.o_tie), 64'd0);
    chk("t5_valid",  64'(sbus.o_valid), 64'd1);
    sbus.i_voting_over = 1'b0; cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
